grb_frame_scheduler: RTL and testbench
======================================

// Module: grb_frame_scheduler
// PURPOSE
//  Sequences the GRB serial shipper for a WS2812-style LED chain of up to 5 LEDs.
//  Keeps a host-writable shadow colour buffer and copies it into an active frame at frame start.
//  Starts each ship with a one-cycle ship_grb pulse and waits for ship_done, then holds the line
//  in return (low) for the latch interval. Frames are launched on host request or by a periodic refresh timer.
// PARAMETERS
//  LATCH_CYCLES    5000     clocks of enforced line-low after a frame (>=50us at 100MHz)
//  REFRESH_CYCLES  1666667  clocks between automatic refresh frames (60Hz at 100MHz)
//  TIMEOUT_CYCLES  8192     max clocks in SHIP waiting for ship_done before abort
// PORTS
//  clk          in   1    system clock, all logic on rising edge
//  reset_n      in   1    asynchronous, active-low reset
//  wr_en        in   1    host write strobe to shadow buffer
//  wr_addr      in   3    LED index 0..4; 5..7 ignored
//  wr_data      in   24   GRB colour {G[7:0],R[7:0],B[7:0]}
//  num_leds     in   3    chain length 1..5; sampled in LOAD
//  refresh_en   in   1    enable periodic refresh frames
//  update_req   in   1    one-cycle pulse: ship current shadow once
//  update_ack   out  1    one-cycle pulse at end of LATCH of the frame serving a request
//  ship_grb     out  1    one-cycle start pulse to the shipper
//  ship_done    in   1    one-cycle pulse from the shipper when the last bit is sent
//  frame_data   out  120  active frame, LED0 in [119:96]; stable from LOAD until IDLE
//  num_leds_enc out  3    shipper length code: 1->000 2->001 3->011 4->111 5->100
//  busy         out  1    high in any state except IDLE
//  err_timeout  out  1    sticky; set on SHIP timeout; cleared only by reset
// BEHAVIOUR
//  Reset values: all outputs 0, except num_leds_enc=000; shadow and frame_data all zero;
//   state IDLE; pending flags clear; refresh counter 0.
//  States: IDLE -> LOAD -> SHIP -> LATCH -> IDLE.
//   IDLE:  go to LOAD when req_pend or ref_pend is set.
//   LOAD:  lasts 1 cycle. frame_data <= shadow. Clamp num_leds (0->1, >5->5) and encode it.
//          serving_req <= req_pend. Clear req_pend and ref_pend.
//   SHIP:  ship_grb is high only in the first SHIP cycle.
//          On ship_done, go to LATCH. If TIMEOUT_CYCLES elapse with no ship_done, set err_timeout and go to LATCH.
//   LATCH: count LATCH_CYCLES clocks, then go to IDLE.
//          update_ack pulses in that same exit cycle if serving_req=1.
//  Shadow writes: accepted in every state, effective the next cycle.
//   Writes during SHIP/LATCH never alter frame_data.
//   A write in the LOAD cycle lands in shadow only; frame_data takes the pre-write value.
//  update_req: sets req_pend in any state. Multiple requests coalesce into one frame.
//   A request during SHIP/LATCH yields exactly one further frame after the current one.
//  Refresh: the counter runs only while refresh_en=1. It sets ref_pend and reloads on reaching REFRESH_CYCLES-1.
//   When refresh_en=0 the counter is held at 0 and ref_pend is cleared.
//  Simultaneous req and refresh expiry: one frame serves both; ack is issued.
//  ship_done outside SHIP is ignored. Minimum gap between ship_grb pulses = 1+LATCH_CYCLES+2 clocks.
//  Counters are sized $clog2(param) and never wrap; each stops at its terminal count.
//  Async reset mid-frame: return to IDLE immediately; no ack; ship_grb low.
// STRUCTURE
//  Package grb_pkg: state enum (IDLE, LOAD, SHIP, LATCH), NUM_LEDS_MAX=5, GRB_W=24,
//   function encode_num_leds(count)->3b code.
//  One sub-module, grb_interval_timer (load/enable/terminal-count down-counter, WIDTH param).
//   Instantiate it for the latch, timeout and refresh timers.
// TESTING
//  1. Write LED0..2 = 0x00FF00, 0x0000FF, 0xFF0000; num_leds=3; update_req
//     -> ship_grb 1 pulse, num_leds_enc=011, frame_data[119:48] matches the writes;
//        update_ack exactly LATCH_CYCLES+1 clocks after ship_done.
//  2. update_req x3 during SHIP -> exactly one further frame after latch, one further ack.
//  3. Write LED0=0x123456 during SHIP -> frame_data unchanged; next frame carries 0x123456.
//  4. refresh_en=1, REFRESH_CYCLES=100 (test override), no req
//     -> ship_grb every frame or every 100 clocks, whichever is longer; update_ack never asserted.
//  5. Withhold ship_done -> err_timeout=1 after TIMEOUT_CYCLES; latch runs, then IDLE; err stays set.
//  6. Assert reset_n low in LATCH -> busy=0 and outputs at reset values asynchronously;
//     no ack; num_leds=0 then req -> num_leds_enc=000 (clamped to 1).

Source files
------------

// File: rtl/grb_pkg.sv
// Shared types and helpers for the GRB frame scheduler.
//   state_t          scheduler FSM states
//   grb_t            one LED colour {G,R,B}
//   encode_num_leds  chain length (clamped to 1..5) -> shipper length code
package grb_pkg;

    localparam int unsigned NUM_LEDS_MAX = 5;
    localparam int unsigned GRB_W        = 24;
    localparam int unsigned FRAME_W      = NUM_LEDS_MAX * GRB_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIP  = 2'd2,
        LATCH = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    // 0 is treated as 1 and anything above 5 as 5 before encoding.
    function automatic logic [2:0] encode_num_leds(input logic [2:0] count);
        case (count)
            3'd0, 3'd1: return 3'b000;
            3'd2:       return 3'b001;
            3'd3:       return 3'b011;
            3'd4:       return 3'b111;
            default:    return 3'b100;
        endcase
    endfunction

endpackage

// File: rtl/grb_interval_timer.sv
// Loadable down-counter that stops at zero.
//   clk, reset_n   clock, async active-low reset (count resets to INIT)
//   load, load_val synchronous reload (has priority over en)
//   en             decrement while nonzero
//   done_c         count is at its terminal value (zero)
module grb_interval_timer #(
    parameter int unsigned     WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             done_c
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= INIT;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done_c = (count == '0);

endmodule

// File: rtl/grb_frame_scheduler.sv
// Frame scheduler for a WS2812-style GRB chain of up to 5 LEDs.
// Keeps a host-written shadow buffer, snapshots it into frame_data at frame
// start, kicks the shipper, waits for completion (with timeout) and holds the
// line low for the latch interval. Frames come from host requests or refresh.
//   wr_en/wr_addr/wr_data  shadow buffer write port (addresses 5..7 ignored)
//   num_leds               chain length, sampled in LOAD
//   refresh_en             periodic refresh enable
//   update_req/update_ack  host frame request and completion pulse
//   ship_grb/ship_done     shipper start pulse and completion pulse
//   frame_data             active frame, LED0 in the top 24 bits
//   num_leds_enc           shipper length code
//   busy                   not in IDLE
//   err_timeout            sticky shipper timeout flag
module grb_frame_scheduler
    import grb_pkg::*;
#(
    parameter int unsigned LATCH_CYCLES   = 5000,
    parameter int unsigned REFRESH_CYCLES = 1666667,
    parameter int unsigned TIMEOUT_CYCLES = 8192
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [2:0]         wr_addr,
    input  logic [GRB_W-1:0]   wr_data,
    input  logic [2:0]         num_leds,
    input  logic               refresh_en,
    input  logic               update_req,
    output logic               update_ack,
    output logic               ship_grb,
    input  logic               ship_done,
    output logic [FRAME_W-1:0] frame_data,
    output logic [2:0]         num_leds_enc,
    output logic               busy,
    output logic               err_timeout
);

    localparam int unsigned LAT_W = (LATCH_CYCLES   > 1) ? $clog2(LATCH_CYCLES)   : 1;
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    state_t state, state_nxt;
    logic   req_pend, ref_pend, serving_req;
    logic   lat_done_c, tmo_done_c, ref_done_c, tmo_expire_c;

    // shadow[4] holds LED0 so the packed array maps straight onto frame_data.
    grb_t [NUM_LEDS_MAX-1:0] shadow;

    // Latch timer: preloaded outside LATCH, counts down LATCH_CYCLES cycles inside it.
    grb_interval_timer #(.WIDTH(LAT_W)) u_latch_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (state != LATCH),
        .en       (state == LATCH),
        .load_val (LAT_W'(LATCH_CYCLES - 1)),
        .done_c   (lat_done_c)
    );

    // Ship timeout: preloaded outside SHIP, expires on the TIMEOUT_CYCLES-th SHIP cycle.
    grb_interval_timer #(.WIDTH(TMO_W)) u_timeout_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (state != SHIP),
        .en       (state == SHIP),
        .load_val (TMO_W'(TIMEOUT_CYCLES - 1)),
        .done_c   (tmo_done_c)
    );

    // Refresh timer: held full while disabled, fires every REFRESH_CYCLES enabled cycles.
    grb_interval_timer #(
        .WIDTH (REF_W),
        .INIT  (REF_W'(REFRESH_CYCLES - 1))
    ) u_refresh_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (!refresh_en || ref_done_c),
        .en       (refresh_en),
        .load_val (REF_W'(REFRESH_CYCLES - 1)),
        .done_c   (ref_done_c)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; ship_done wins over a timeout in the same cycle.
    always_comb begin
        state_nxt    = state;
        tmo_expire_c = 1'b0;
        case (state)
            IDLE:    if (req_pend || ref_pend) state_nxt = LOAD;
            LOAD:    state_nxt = SHIP;
            SHIP: begin
                if (ship_done) begin
                    state_nxt = LATCH;
                end else if (tmo_done_c) begin
                    tmo_expire_c = 1'b1;
                    state_nxt    = LATCH;
                end
            end
            LATCH:   if (lat_done_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow buffer, pending flags, frame snapshot and registered outputs.
    // New requests/expiries in the LOAD cycle win over LOAD's clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow       <= '0;
            req_pend     <= 1'b0;
            ref_pend     <= 1'b0;
            serving_req  <= 1'b0;
            frame_data   <= '0;
            num_leds_enc <= 3'b000;
            ship_grb     <= 1'b0;
            update_ack   <= 1'b0;
            busy         <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (wr_en && (wr_addr < 3'(NUM_LEDS_MAX))) begin
                shadow[3'(NUM_LEDS_MAX - 1) - wr_addr] <= grb_t'(wr_data);
            end

            if (update_req) begin
                req_pend <= 1'b1;
            end else if (state == LOAD) begin
                req_pend <= 1'b0;
            end

            if (!refresh_en) begin
                ref_pend <= 1'b0;
            end else if (ref_done_c) begin
                ref_pend <= 1'b1;
            end else if (state == LOAD) begin
                ref_pend <= 1'b0;
            end

            if (state == LOAD) begin
                frame_data   <= shadow;
                num_leds_enc <= encode_num_leds(num_leds);
                serving_req  <= req_pend;
            end

            ship_grb   <= (state == LOAD);
            update_ack <= (state == LATCH) && lat_done_c && serving_req;
            busy       <= (state_nxt != IDLE);

            if (tmo_expire_c) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_grb_frame_scheduler.sv
// Self-checking bench for grb_frame_scheduler: directed scenarios plus a
// randomized phase, with a per-cycle behavioural model of the frame rules.
module tb_grb_frame_scheduler;

    localparam int L = 20;
    localparam int R = 100;
    localparam int T = 64;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         wr_en = 1'b0;
    logic [2:0]   wr_addr = 3'd0;
    logic [23:0]  wr_data = 24'd0;
    logic [2:0]   num_leds = 3'd3;
    logic         refresh_en = 1'b0;
    logic         update_req = 1'b0;
    logic         ship_done = 1'b0;
    logic         update_ack, ship_grb, busy, err_timeout;
    logic [119:0] frame_data;
    logic [2:0]   num_leds_enc;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    bit withhold = 1'b0;
    bit spurious_en = 1'b0;
    bit rand_delay = 1'b0;
    int ship_delay = 4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    grb_frame_scheduler #(
        .LATCH_CYCLES   (L),
        .REFRESH_CYCLES (R),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .num_leds     (num_leds),
        .refresh_en   (refresh_en),
        .update_req   (update_req),
        .update_ack   (update_ack),
        .ship_grb     (ship_grb),
        .ship_done    (ship_done),
        .frame_data   (frame_data),
        .num_leds_enc (num_leds_enc),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Shipper stand-in: answers each ship_grb with ship_done after a delay.
    int cd = -1;
    always @(negedge clk) begin
        ship_done = 1'b0;
        if (!reset_n) begin
            cd = -1;
        end else begin
            if (ship_grb && !withhold) cd = rand_delay ? int'($urandom_range(0, 70)) : ship_delay;
            if (cd == 0) ship_done = 1'b1;
            if (cd >= 0) cd--;
            if (spurious_en && ($urandom_range(0, 63) == 0)) ship_done = 1'b1;
        end
    end

    // Behavioural model: phase 0 idle, 1 load, 2 ship, 3 latch; el = cycles spent in phase.
    function automatic logic [2:0] enc_model(input int n);
        int k;
        k = (n < 1) ? 1 : ((n > 5) ? 5 : n);
        case (k)
            1: return 3'b000;
            2: return 3'b001;
            3: return 3'b011;
            4: return 3'b111;
            default: return 3'b100;
        endcase
    endfunction

    int           m_phase = 0, m_el = 0, ref_cnt = 0;
    bit           req_p = 0, ref_p = 0, serving = 0;
    logic [23:0]  m_sh [5] = '{default: 24'd0};
    logic [119:0] m_frame = '0;
    logic [2:0]   m_enc = 3'b000;
    bit           m_ship = 0, m_ack = 0, m_busy = 0, m_err = 0;

    always @(posedge clk or negedge reset_n) begin : model
        int nph;
        bit ack, shp;
        if (!reset_n) begin
            m_phase = 0; m_el = 0; ref_cnt = 0;
            req_p = 0; ref_p = 0; serving = 0;
            for (int i = 0; i < 5; i++) m_sh[i] = 24'd0;
            m_frame = '0; m_enc = 3'b000;
            m_ship = 0; m_ack = 0; m_busy = 0; m_err = 0;
        end else begin
            nph = m_phase; ack = 0; shp = 0;
            case (m_phase)
                0: if (req_p || ref_p) nph = 1;
                1: begin
                    nph = 2; m_el = 1; shp = 1;
                    m_frame = {m_sh[0], m_sh[1], m_sh[2], m_sh[3], m_sh[4]};
                    m_enc = enc_model(int'(num_leds));
                    serving = req_p;
                end
                2: begin
                    if (ship_done) begin
                        nph = 3; m_el = 1;
                    end else if (m_el == T) begin
                        m_err = 1; nph = 3; m_el = 1;
                    end else m_el++;
                end
                default: begin
                    if (m_el == L) begin
                        nph = 0; ack = serving;
                    end else m_el++;
                end
            endcase
            if (!refresh_en) begin
                ref_p = 0; ref_cnt = 0;
            end else if (ref_cnt == R - 1) begin
                ref_p = 1; ref_cnt = 0;
            end else begin
                ref_cnt++;
                if (m_phase == 1) ref_p = 0;
            end
            if (update_req) req_p = 1;
            else if (m_phase == 1) req_p = 0;
            if (wr_en && (wr_addr < 3'd5)) m_sh[wr_addr] = wr_data;
            m_ship = shp; m_ack = ack; m_busy = (nph != 0);
            m_phase = nph;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("ship_grb", {127'd0, ship_grb}, {127'd0, m_ship});
        check("update_ack", {127'd0, update_ack}, {127'd0, m_ack});
        check("busy", {127'd0, busy}, {127'd0, m_busy});
        check("err_timeout", {127'd0, err_timeout}, {127'd0, m_err});
        check("num_leds_enc", {125'd0, num_leds_enc}, {125'd0, m_enc});
        check("frame_data", {8'd0, frame_data}, {8'd0, m_frame});
    end

    task automatic wr(input int a, input logic [23:0] d);
        @(negedge clk); wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
        @(negedge clk); wr_en = 1'b0;
    endtask

    task automatic req();
        @(negedge clk); update_req = 1'b1;
        @(negedge clk); update_req = 1'b0;
    endtask

    task automatic wait_ship(input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (ship_grb) begin at = cyc; break; end
        end
        if (at < 0) check("wait_ship_timeout", 128'd0, 128'd1);
    endtask

    task automatic wait_done(input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk);
            if (ship_done) begin at = cyc; break; end
        end
        if (at < 0) check("wait_done_timeout", 128'd0, 128'd1);
    endtask

    task automatic wait_ack(input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (update_ack) begin at = cyc; break; end
        end
        if (at < 0) check("wait_ack_timeout", 128'd0, 128'd1);
    endtask

    task automatic wait_err(input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (err_timeout) begin at = cyc; break; end
        end
        if (at < 0) check("wait_err_timeout", 128'd0, 128'd1);
    endtask

    task automatic wait_idle(input int maxc);
        bit ok;
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) check("wait_idle_timeout", 128'd0, 128'd1);
    endtask

    task automatic count_window(input int n, output int ships, output int acks);
        ships = 0; acks = 0;
        repeat (n) begin
            @(negedge clk);
            if (ship_grb) ships++;
            if (update_ack) acks++;
        end
    endtask

    initial begin
        int s, s2, d, a, e, ships, acks;

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {127'd0, busy}, 128'd0);
        check("reset_enc", {125'd0, num_leds_enc}, 128'd0);
        check("reset_frame", {8'd0, frame_data}, 128'd0);
        reset_n = 1'b1;

        // 1: basic frame of three LEDs
        ship_delay = 4;
        wr(0, 24'h00FF00); wr(1, 24'h0000FF); wr(2, 24'hFF0000);
        num_leds = 3'd3;
        req();
        wait_ship(20, s);
        check("t1_enc", {125'd0, num_leds_enc}, {125'd0, 3'b011});
        check("t1_frame", {56'd0, frame_data[119:48]}, {56'd0, 72'h00FF00_0000FF_FF0000});
        wait_done(50, d);
        wait_ack(100, a);
        check("t1_ack_latency", 128'(a - d), 128'(L + 1));
        wait_idle(50);

        // 2: three requests during SHIP coalesce into one further frame
        ship_delay = 30;
        req();
        wait_ship(20, s);
        repeat (3) begin
            update_req = 1'b1; @(negedge clk);
            update_req = 1'b0; @(negedge clk);
        end
        count_window(200, ships, acks);
        check("t2_ships", 128'(ships), 128'd1);
        check("t2_acks", 128'(acks), 128'd2);

        // 3: shadow write during SHIP only affects the next frame
        req();
        wait_ship(20, s);
        wr(0, 24'h123456);
        @(negedge clk);
        check("t3_frame_hold", {104'd0, frame_data[119:96]}, {104'd0, 24'h00FF00});
        wait_idle(200);
        req();
        wait_ship(20, s);
        check("t3_frame_new", {104'd0, frame_data[119:96]}, {104'd0, 24'h123456});
        wait_idle(200);

        // 4: periodic refresh, no acknowledgements
        ship_delay = 5;
        @(negedge clk); refresh_en = 1'b1;
        wait_ship(150, s);
        wait_ship(150, s2);
        check("t4_period", 128'(s2 - s), 128'(R));
        count_window(250, ships, acks);
        check("t4_ships", 128'(ships), 128'd2);
        check("t4_acks", 128'(acks), 128'd0);
        @(negedge clk); refresh_en = 1'b0;
        wait_idle(200);

        // 5: withheld ship_done -> timeout, latch, idle; error sticks
        withhold = 1'b1;
        req();
        wait_ship(20, s);
        wait_err(200, e);
        check("t5_err_latency", 128'(e - s), 128'(T));
        check("t5_busy_in_latch", {127'd0, busy}, 128'd1);
        repeat (L - 1) @(negedge clk);
        check("t5_busy_last_latch", {127'd0, busy}, 128'd1);
        @(negedge clk);
        check("t5_idle", {127'd0, busy}, 128'd0);
        check("t5_err_sticky", {127'd0, err_timeout}, 128'd1);
        withhold = 1'b0;

        // 6: async reset in LATCH, then clamping of num_leds
        ship_delay = 3;
        req();
        wait_done(50, d);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t6_busy", {127'd0, busy}, 128'd0);
        check("t6_ship", {127'd0, ship_grb}, 128'd0);
        check("t6_ack", {127'd0, update_ack}, 128'd0);
        check("t6_err", {127'd0, err_timeout}, 128'd0);
        check("t6_enc", {125'd0, num_leds_enc}, 128'd0);
        check("t6_frame", {8'd0, frame_data}, 128'd0);
        @(negedge clk); reset_n = 1'b1;
        count_window(40, ships, acks);
        check("t6_no_ship", 128'(ships), 128'd0);
        check("t6_no_ack", 128'(acks), 128'd0);
        num_leds = 3'd0;
        req();
        wait_ship(20, s);
        check("t6_enc_zero", {125'd0, num_leds_enc}, {125'd0, 3'b000});
        wait_idle(100);
        num_leds = 3'd7;
        req();
        wait_ship(20, s);
        check("t6_enc_seven", {125'd0, num_leds_enc}, {125'd0, 3'b100});
        wait_idle(100);

        // Randomized traffic checked cycle by cycle against the model
        spurious_en = 1'b1;
        rand_delay  = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_addr    = 3'($urandom_range(0, 7));
            wr_data    = 24'($urandom);
            update_req = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) num_leds = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) refresh_en = ~refresh_en;
        end
        @(negedge clk);
        wr_en = 1'b0; update_req = 1'b0; refresh_en = 1'b0;
        spurious_en = 1'b0; rand_delay = 1'b0;
        wait_idle(400);
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
